// File: rtl/unidade_es.sv
// unidade_es: execute-stage I/O unit that latches OUT onto a display and stalls IN until a debounced button press
module unidade_es #(
   parameter int DEBOUNCE = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  Opcode,
   input  logic [31:0] Resultado,
   input  logic        Valido,
   input  logic [15:0] Chaves,
   input  logic        Confirma,
   output logic        Pausa,
   output logic [31:0] DadoEntrada,
   output logic        EscreveReg,
   output logic [31:0] Saida,
   output logic        SaidaValida
);
   localparam logic [5:0]  OP_IN  = 6'b001000;
   localparam logic [5:0]  OP_OUT = 6'b001001;
   localparam logic [15:0] LIMITE = 16'(DEBOUNCE - 1);
   typedef enum logic [1:0] {OCIOSO, ESPERA_SOLTA, ESPERA_APERTO, ENTREGA} estado_t;
   estado_t     r_estado, w_prox;
   logic        r_sinc1, r_conf_s;
   logic [15:0] r_cont;
   logic [31:0] r_dado, r_saida;
   logic        r_saida_valida;
   logic        w_in, w_out, w_aceita;
   assign w_in        = Valido && (Opcode == OP_IN);
   assign w_out       = Valido && (Opcode == OP_OUT);
   assign w_aceita    = (r_estado == ESPERA_APERTO) && r_conf_s && (r_cont == LIMITE);
   assign DadoEntrada = r_dado;
   assign Saida       = r_saida;
   assign SaidaValida = r_saida_valida;
   // two-flop synchronizer for the raw push-button
   always_ff @(posedge clock) begin
      r_sinc1  <= reset ? Confirma : 1'b0;
      r_conf_s <= reset ? r_sinc1 : 1'b0;
   end
   // state register
   always_ff @(posedge clock)
      r_estado <= reset ? w_prox : OCIOSO;
   // next state and stall/writeback outputs; the IN stall in OCIOSO is combinational
   always_comb begin
      w_prox     = r_estado;
      Pausa      = 1'b0;
      EscreveReg = 1'b0;
      case (r_estado)
         OCIOSO: begin
            Pausa = w_in;
            if (w_in) w_prox = r_conf_s ? ESPERA_SOLTA : ESPERA_APERTO;
         end
         ESPERA_SOLTA: begin
            Pausa = 1'b1;
            if (!r_conf_s) w_prox = ESPERA_APERTO;
         end
         ESPERA_APERTO: begin
            Pausa = 1'b1;
            if (w_aceita) w_prox = ENTREGA;
         end
         default: begin
            EscreveReg = 1'b1;
            w_prox     = OCIOSO;
         end
      endcase
   end
   // debounce counter: counts consecutive high cycles while waiting for a press, saturates at the limit
   always_ff @(posedge clock)
      if (!reset)
         r_cont <= '0;
      else if (r_estado == ESPERA_APERTO && r_conf_s)
         r_cont <= (r_cont == LIMITE) ? r_cont : r_cont + 16'd1;
      else
         r_cont <= '0;
   // switch capture on acceptance and display latch on OUT
   always_ff @(posedge clock)
      if (!reset) begin
         r_dado         <= '0;
         r_saida        <= '0;
         r_saida_valida <= 1'b0;
      end else begin
         if (w_aceita) r_dado <= {16'b0, Chaves};
         if (r_estado == OCIOSO && w_out) begin
            r_saida        <= Resultado;
            r_saida_valida <= 1'b1;
         end
      end
endmodule
